// File: rtl/mealey_stream_checker.sv
// rtl/mealey_stream_checker.sv - receive-side sample stream checker for the Mealey stimulus bench
// Compares each valid sample against an arithmetic expected sequence; reports done/pass, error count and first mismatch.
module mealey_stream_checker #(
  parameter int WIDTH       = 9,
  parameter int NUM_SAMPLES = 16,
  parameter int SKIP        = 1,
  parameter int EXP_START   = 0,
  parameter int EXP_STEP    = 1
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    start,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] sample_i,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_count,
  output logic [7:0]              first_err_idx,
  output logic signed [WIDTH-1:0] first_err_val
);

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_CHECK, ST_DONE} state_t;

  localparam logic [7:0]              LAST_IDX  = 8'(NUM_SAMPLES - 1);
  localparam logic [3:0]              LAST_SKIP = 4'(SKIP - 1);
  localparam logic signed [WIDTH-1:0] EXP_INIT  = WIDTH'(EXP_START);
  localparam logic signed [WIDTH-1:0] EXP_INC   = WIDTH'(EXP_STEP);

  state_t                    state;
  logic signed [WIDTH-1:0]   exp_val;
  logic [7:0]                idx;
  logic [3:0]                skip_cnt;
  logic                      mismatch;
  logic [7:0]                err_next;

  // Case inequality so X/Z on the sample is flagged as a mismatch in simulation.
  always_comb begin
    mismatch = (sample_i !== exp_val);
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF))
      err_next = err_count + 8'd1;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state         <= ST_IDLE;
      exp_val       <= '0;
      idx           <= '0;
      skip_cnt      <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_val <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A sample arriving on the start edge is deliberately not consumed.
          if (start) begin
            state         <= (SKIP > 0) ? ST_SKIP : ST_CHECK;
            exp_val       <= EXP_INIT;
            idx           <= '0;
            skip_cnt      <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_val <= '0;
          end
        end
        ST_SKIP: begin
          if (sample_valid) begin
            skip_cnt <= skip_cnt + 4'd1;
            if (skip_cnt == LAST_SKIP)
              state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (sample_valid) begin
            err_count <= err_next;
            if (mismatch && (err_count == 8'd0)) begin
              first_err_idx <= idx;
              first_err_val <= sample_i;
            end
            exp_val <= exp_val + EXP_INC;
            idx     <= idx + 8'd1;
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= (err_next == 8'd0);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mealey_stream_checker.sv
// tb/tb_mealey_stream_checker.sv - randomized self-checking bench for mealey_stream_checker
// Three differently parameterised checkers share one clock; a queue-based model predicts each run's result.
module tb_mealey_stream_checker;

  localparam int P_N     [3] = '{16, 4, 255};
  localparam int P_SKIP  [3] = '{1, 0, 2};
  localparam int P_START [3] = '{0, 250, -5};
  localparam int P_STEP  [3] = '{1, 3, -7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic              start_v [3];
  logic              valid_v [3];
  logic signed [8:0] smp     [3];
  logic              done_v  [3];
  logic              pass_v  [3];
  logic [7:0]        ec      [3];
  logic [7:0]        fi      [3];
  logic signed [8:0] fv      [3];

  mealey_stream_checker #(.WIDTH(9), .NUM_SAMPLES(16), .SKIP(1), .EXP_START(0), .EXP_STEP(1)) u0 (
    .system1000(clk), .system1000_rstn(rstn), .start(start_v[0]), .sample_valid(valid_v[0]),
    .sample_i(smp[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(ec[0]),
    .first_err_idx(fi[0]), .first_err_val(fv[0]));

  mealey_stream_checker #(.WIDTH(9), .NUM_SAMPLES(4), .SKIP(0), .EXP_START(250), .EXP_STEP(3)) u1 (
    .system1000(clk), .system1000_rstn(rstn), .start(start_v[1]), .sample_valid(valid_v[1]),
    .sample_i(smp[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(ec[1]),
    .first_err_idx(fi[1]), .first_err_val(fv[1]));

  mealey_stream_checker #(.WIDTH(9), .NUM_SAMPLES(255), .SKIP(2), .EXP_START(-5), .EXP_STEP(-7)) u2 (
    .system1000(clk), .system1000_rstn(rstn), .start(start_v[2]), .sample_valid(valid_v[2]),
    .sample_i(smp[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(ec[2]),
    .first_err_idx(fi[2]), .first_err_val(fv[2]));

  int n_vec = 0;
  int n_err = 0;
  int stim_q [$];
  int m_err, m_idx, m_val;
  bit m_pass;

  // Map any integer onto the signed 9-bit range (mod 512).
  function automatic int wrap9(int x);
    int r;
    r = x & 511;
    return (r >= 256) ? r - 512 : r;
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic gen(int u, int pct);
    int v;
    stim_q.delete();
    for (int i = 0; i < P_SKIP[u]; i++)
      stim_q.push_back(wrap9(int'($urandom)));
    for (int k = 0; k < P_N[u]; k++) begin
      v = wrap9(P_START[u] + k * P_STEP[u]);
      if (int'($urandom_range(99)) < pct)
        v = wrap9(v + int'($urandom_range(1, 511)));
      stim_q.push_back(v);
    end
  endtask

  task automatic model(int u);
    int v;
    m_err = 0;
    m_idx = 0;
    m_val = 0;
    for (int k = 0; k < P_N[u]; k++) begin
      v = stim_q[P_SKIP[u] + k];
      if (v != wrap9(P_START[u] + k * P_STEP[u])) begin
        if (m_err == 0) begin
          m_idx = k;
          m_val = v;
        end
        if (m_err < 255)
          m_err++;
      end
    end
    m_pass = (m_err == 0);
  endtask

  task automatic run(int u, bit toggle, bit hold);
    model(u);
    @(negedge clk);
    start_v[u] = 1'b1;
    valid_v[u] = 1'b0;
    @(negedge clk);
    start_v[u] = hold;
    check("done_clear", done_v[u], 0);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (toggle) begin
        valid_v[u] = 1'b0;
        smp[u] = 9'($urandom);
        @(negedge clk);
      end
      valid_v[u] = 1'b1;
      smp[u] = 9'(stim_q[i]);
      if (i == stim_q.size() - 1)
        check("done_early", done_v[u], 0);
      @(negedge clk);
    end
    valid_v[u] = 1'b0;
    start_v[u] = 1'b0;
    check("done", done_v[u], 1);
    check("pass", pass_v[u], int'(m_pass));
    check("err_count", int'(ec[u]), m_err);
    check("first_err_idx", int'(fi[u]), m_idx);
    check("first_err_val", int'(fv[u]), m_val);
    for (int c = 0; c < 3; c++) begin
      valid_v[u] = 1'b1;
      smp[u] = 9'($urandom);
      @(negedge clk);
    end
    valid_v[u] = 1'b0;
    check("done_hold", done_v[u], 1);
    check("err_hold", int'(ec[u]), m_err);
  endtask

  initial begin
    rstn = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b0;
      valid_v[u] = 1'b0;
      smp[u] = '0;
    end
    #2;
    check("rst_done", done_v[0], 0);
    check("rst_pass", pass_v[0], 0);
    check("rst_err", int'(ec[0]), 0);
    check("rst_fidx", int'(fi[0]), 0);
    check("rst_fval", int'(fv[0]), 0);
    #1 rstn = 1'b1;

    gen(0, 0);
    run(0, 1'b0, 1'b0);
    gen(0, 0);
    stim_q[P_SKIP[0] + 5] = 100;
    run(0, 1'b0, 1'b0);
    gen(0, 0);
    run(0, 1'b1, 1'b1);
    repeat (6) begin
      gen(0, int'($urandom_range(0, 25)));
      run(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    stim_q = '{250, 253, -256, -253};
    run(1, 1'b0, 1'b0);
    repeat (4) begin
      gen(1, 30);
      run(1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    gen(2, 100);
    run(2, 1'b0, 1'b0);
    gen(2, 10);
    run(2, 1'b1, 1'b1);

    // Abort a run partway through CHECK with errors already accumulated.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid_v[0] = 1'b1;
      smp[0] = (i == 0) ? 9'sd0 : 9'(i + 199);
      @(negedge clk);
    end
    valid_v[0] = 1'b0;
    check("pre_rst_err", int'(ec[0]), 7);
    check("pre_rst_done", done_v[0], 0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_err", int'(ec[0]), 0);
    check("abort_fidx", int'(fi[0]), 0);
    check("abort_fval", int'(fv[0]), 0);
    check("abort_done", done_v[0], 0);
    check("abort_pass", pass_v[0], 0);
    check("abort_done_u2", done_v[2], 0);
    @(negedge clk);
    rstn = 1'b1;
    gen(0, 0);
    run(0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
